// File: rtl/decoder_4_5_pkg.sv
// rtl/decoder_4_5_pkg.sv - shared widths and FSM encoding for the FNS 4-to-9 decoder
package decoder_4_5_pkg;

    localparam int BLEN_04    = 4;
    localparam int CODE_W_45  = 9;
    localparam int DEC_ACC_W  = 8;
    localparam int IDX_W      = 4;
    localparam int FNSLEN_03  = 2;
    localparam int FNSLEN_04  = 2;
    localparam int FNSLEN_05  = 4;

    typedef enum logic [1:0] {
        DEC_IDLE  = 2'd0,
        DEC_ACCUM = 2'd1,
        DEC_DONE  = 2'd2
    } dec_state_t;

endpackage

// File: rtl/fns_weight_sel.sv
// rtl/fns_weight_sel.sv - picks the Fibonacci weight of one codeword bit, zero-extended
module fns_weight_sel
    import decoder_4_5_pkg::*;
#(
    parameter int ACC_W = DEC_ACC_W
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic                 fns02,
    input  logic [FNSLEN_03-1:0] fns03,
    input  logic [FNSLEN_04-1:0] fns04,
    input  logic [FNSLEN_05-1:0] fns05,
    input  logic [FNSLEN_05-1:0] fns06,
    input  logic [FNSLEN_05-1:0] fns07,
    input  logic [FNSLEN_05-1:0] fns08,
    input  logic [FNSLEN_05-1:0] fns09,
    output logic [ACC_W-1:0]     weight
);

    always_comb begin
        weight = '0;
        case (idx)
            4'd0:    weight = ACC_W'(1);
            4'd1:    weight = ACC_W'(fns02);
            4'd2:    weight = ACC_W'(fns03);
            4'd3:    weight = ACC_W'(fns04);
            4'd4:    weight = ACC_W'(fns05);
            4'd5:    weight = ACC_W'(fns06);
            4'd6:    weight = ACC_W'(fns07);
            4'd7:    weight = ACC_W'(fns08);
            4'd8:    weight = ACC_W'(fns09);
            default: weight = '0;
        endcase
    end

endmodule

// File: rtl/decoder_4_5.sv
// rtl/decoder_4_5.sv - serial MSB-first weight accumulator decoding a 9-wire FNS codeword
module decoder_4_5
    import decoder_4_5_pkg::*;
#(
    parameter int DATA_W = BLEN_04,
    parameter int CODE_W = CODE_W_45,
    parameter int ACC_W  = DEC_ACC_W
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_W-1:0]    codein,
    input  logic [CODE_W-1:0]    en_flag,
    input  logic                 FNS02,
    input  logic [FNSLEN_03-1:0] FNS03,
    input  logic [FNSLEN_04-1:0] FNS04,
    input  logic [FNSLEN_05-1:0] FNS05,
    input  logic [FNSLEN_05-1:0] FNS06,
    input  logic [FNSLEN_05-1:0] FNS07,
    input  logic [FNSLEN_05-1:0] FNS08,
    input  logic [FNSLEN_05-1:0] FNS09,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    data_out,
    output logic                 err
);

    dec_state_t           state_q, state_d;
    logic [CODE_W-1:0]    masked_q;
    logic                 fns02_q;
    logic [FNSLEN_03-1:0] fns03_q;
    logic [FNSLEN_04-1:0] fns04_q;
    logic [FNSLEN_05-1:0] fns05_q, fns06_q, fns07_q, fns08_q, fns09_q;
    logic [IDX_W-1:0]     idx_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     weight;
    logic [ACC_W-1:0]     acc_sum;

    fns_weight_sel #(.ACC_W(ACC_W)) u_weight_sel (
        .idx    (idx_q),
        .fns02  (fns02_q),
        .fns03  (fns03_q),
        .fns04  (fns04_q),
        .fns05  (fns05_q),
        .fns06  (fns06_q),
        .fns07  (fns07_q),
        .fns08  (fns08_q),
        .fns09  (fns09_q),
        .weight (weight)
    );

    assign acc_sum   = acc_q + (masked_q[idx_q] ? weight : '0);
    assign in_ready  = (state_q == DEC_IDLE);
    assign out_valid = (state_q == DEC_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            DEC_IDLE:  if (in_valid) state_d = DEC_ACCUM;
            DEC_ACCUM: if (idx_q == '0) state_d = DEC_DONE;
            DEC_DONE:  if (out_ready) state_d = DEC_IDLE;
            default:   state_d = DEC_IDLE;
        endcase
    end

    // Only the snapshot registers feed the accumulator, so input changes mid-word are harmless.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DEC_IDLE;
            masked_q <= '0;
            fns02_q  <= '0;
            fns03_q  <= '0;
            fns04_q  <= '0;
            fns05_q  <= '0;
            fns06_q  <= '0;
            fns07_q  <= '0;
            fns08_q  <= '0;
            fns09_q  <= '0;
            idx_q    <= IDX_W'(CODE_W - 1);
            acc_q    <= '0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                DEC_IDLE: begin
                    if (in_valid) begin
                        masked_q <= codein & en_flag;
                        fns02_q  <= FNS02;
                        fns03_q  <= FNS03;
                        fns04_q  <= FNS04;
                        fns05_q  <= FNS05;
                        fns06_q  <= FNS06;
                        fns07_q  <= FNS07;
                        fns08_q  <= FNS08;
                        fns09_q  <= FNS09;
                        acc_q    <= '0;
                        idx_q    <= IDX_W'(CODE_W - 1);
                    end
                end
                DEC_ACCUM: begin
                    acc_q <= acc_sum;
                    if (idx_q != '0) begin
                        idx_q <= idx_q - 1'b1;
                    end else begin
                        data_out <= acc_sum[DATA_W-1:0];
                        err      <= (acc_sum > ACC_W'((2 ** DATA_W) - 1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_4_5.sv
// tb/tb_decoder_4_5.sv - table-driven scoreboard bench for decoder_4_5
module tb_decoder_4_5;
    import decoder_4_5_pkg::*;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] codein;
    logic [8:0] en_flag;
    logic       FNS02;
    logic [1:0] FNS03, FNS04;
    logic [3:0] FNS05, FNS06, FNS07, FNS08, FNS09;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data_out;
    logic       err;

    always #5 clock = ~clock;

    decoder_4_5 dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .codein    (codein),
        .en_flag   (en_flag),
        .FNS02     (FNS02),
        .FNS03     (FNS03),
        .FNS04     (FNS04),
        .FNS05     (FNS05),
        .FNS06     (FNS06),
        .FNS07     (FNS07),
        .FNS08     (FNS08),
        .FNS09     (FNS09),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .err       (err)
    );

    typedef struct {
        logic [3:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        logic [8:0] code;
        logic [8:0] en;
        logic [3:0] data;
        logic       err;
    } vec_t;

    exp_t exp_q[$];
    int   acc_edges[$];
    int   acc_log[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   ov_prev = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int sum);
        exp_t e;
        e.data = sum[3:0];
        e.err  = (sum > 15);
        return e;
    endfunction

    function automatic int model(input logic [8:0] c, input logic [8:0] e);
        int w[9];
        int s;
        w[0] = 1;          w[1] = int'(FNS02); w[2] = int'(FNS03);
        w[3] = int'(FNS04); w[4] = int'(FNS05); w[5] = int'(FNS06);
        w[6] = int'(FNS07); w[7] = int'(FNS08); w[8] = int'(FNS09);
        s = 0;
        for (int i = 0; i < 9; i++) if (c[i] && e[i]) s += w[i];
        return s;
    endfunction

    // Caller is at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [8:0] c, input logic [8:0] e, input exp_t x, input bit hold);
        int n;
        bit rdy;
        n = 0;
        codein   = c;
        en_flag  = e;
        in_valid = 1'b1;
        exp_q.push_back(x);
        do begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("accept_timeout", 0, 1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                acc_edges.push_back(cyc + 1);
                acc_log.push_back(cyc + 1);
            end
            if (out_valid && !ov_prev) begin
                if (acc_edges.size() == 0) chk("unexpected_out_valid", 1, 0);
                else chk("latency", cyc - acc_edges.pop_front(), 9);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("data_out", data_out, mon_e.data);
                    chk("err", err, mon_e.err);
                end
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int n;
        vecs[0] = '{9'b100100001, 9'h1FF, 4'd12, 1'b0};
        vecs[1] = '{9'b100100001, 9'h1DF, 4'd9,  1'b0};
        vecs[2] = '{9'b111000000, 9'h1FF, 4'd2,  1'b1};
        vecs[3] = '{9'b111111111, 9'h1FF, 4'd14, 1'b1};
        vecs[4] = '{9'b000000000, 9'h1FF, 4'd0,  1'b0};
        vecs[5] = '{9'b000001111, 9'h1FF, 4'd6,  1'b0};
        vecs[6] = '{9'b010101010, 9'h1FF, 4'd11, 1'b0};
        vecs[7] = '{9'b111111111, 9'h000, 4'd0,  1'b0};
        vecs[8] = '{9'b110100000, 9'h1FF, 4'd0,  1'b1};
        vecs[9] = '{9'b110001000, 9'h1FF, 4'd15, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        codein = '0; en_flag = '0;
        FNS02 = 1'b1; FNS03 = 2'd2; FNS04 = 2'd2; FNS05 = 4'd3;
        FNS06 = 4'd3; FNS07 = 4'd5; FNS08 = 4'd5; FNS09 = 4'd8;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_err", err, 0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].code, vecs[i].en, '{vecs[i].data, vecs[i].err}, 1'b0);
            drain();
        end

        // Inputs change after capture; snapshot must keep the original result.
        send(9'b100100001, 9'h1FF, mk(model(9'b100100001, 9'h1FF)), 1'b0);
        repeat (2) begin @(posedge clock); #1; end
        codein = '0;
        FNS09  = 4'd0;
        drain();
        FNS09 = 4'd8;

        // Backpressure: result held in DONE, second word waits for the handshake.
        out_ready = 1'b0;
        send(9'b010010011, 9'h1FF, mk(model(9'b010010011, 9'h1FF)), 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clock); #1; n++; end
        chk("bp_out_valid_timeout", out_valid, 1);
        fork
            begin
                repeat (5) begin
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                    chk("bp_data_out", data_out, 10);
                    chk("bp_err", err, 0);
                    @(posedge clock);
                    #1;
                end
                out_ready = 1'b1;
            end
            send(9'b000100100, 9'h1FF, mk(model(9'b000100100, 9'h1FF)), 1'b0);
        join
        drain();

        // Throughput: three words back to back.
        acc_log.delete();
        send(9'b100000001, 9'h1FF, mk(model(9'b100000001, 9'h1FF)), 1'b1);
        send(9'b011000000, 9'h1FF, mk(model(9'b011000000, 9'h1FF)), 1'b1);
        send(9'b000000110, 9'h1FF, mk(model(9'b000000110, 9'h1FF)), 1'b0);
        drain();
        chk("tp_accepts", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("tp_spacing_1", acc_log[1] - acc_log[0], 11);
            chk("tp_spacing_2", acc_log[2] - acc_log[1], 11);
        end

        // Reset at ACCUM cycle 4 discards the word.
        send(9'b111111111, 9'h1FF, mk(model(9'b111111111, 9'h1FF)), 1'b0);
        repeat (4) begin @(posedge clock); #1; end
        rst_n = 1'b0;
        exp_q.delete();
        acc_edges.delete();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        send(9'b000000011, 9'h1FF, mk(2), 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/decoder_4_5.md
# decoder_4_5

Sequential decoder for the 4-bit-to-9-wire local-adaptive FNS crosstalk-avoidance code. It sits at the receive end of the TSV bundle. It accepts one registered 9-bit codeword together with the enable mask and Fibonacci weights that were in force when the word was encoded. It then reconstructs the 4-bit data word by serially accumulating the weights of the enabled set bits, MSB first. The result is presented through a valid/ready handshake with a range-error flag.

## Interface
Parameters:
- DATA_W, `BLEN_04 (4): decoded data width.
- CODE_W, 9: codeword width (x+y).
- ACC_W, 8: accumulator width; must hold the sum of all nine weights.

Ports:
- clock, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: codein/en_flag/FNS inputs are valid.
- in_ready, out, 1: decoder can accept a word.
- codein, in, CODE_W: received codeword.
- en_flag, in, CODE_W: per-wire enable; disabled wires contribute 0.
- FNS02, in, 1: weight of codein[1].
- FNS03, in, `FNSLEN_03: weight of codein[2].
- FNS04, in, `FNSLEN_04: weight of codein[3].
- FNS05 … FNS09, in, `FNSLEN_05 each: weights of codein[4] … codein[8].
- Weight of codein[0] is fixed at 1.
- out_valid, out, 1: data_out/err are valid.
- out_ready, in, 1: consumer accepts the result.
- data_out, out, DATA_W: decoded word, ACC[DATA_W-1:0].
- err, out, 1: accumulated sum exceeded 2^DATA_W−1.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture (codein & en_flag), FNS02…FNS09 into snapshot registers.
  - Clear acc to 0; set bit index idx=CODE_W−1; go to ACCUM.
- ACCUM:
  - Each cycle: acc <= acc + (masked[idx] ? weight(idx) : 0); idx decrements.
  - When idx==0 is processed, go to DONE.
  - Inputs changing during ACCUM have no effect; only snapshots are used.
- DONE:
  - out_valid=1; data_out and err hold stable.
  - On out_ready, go to IDLE.
- Weights are zero-extended to ACC_W before addition. acc never wraps because ACC_W covers the worst-case sum.
- err = (acc > 2^DATA_W−1), registered on entry to DONE. data_out carries the truncated low bits regardless of err.
- in_valid while not in IDLE is ignored; the producer holds the word until in_ready.

## Timing
- Reset values (async, immediate): state=IDLE, in_ready=1 once reset deasserts, out_valid=0, data_out=0, err=0, acc=0, idx=CODE_W−1.
- Accepting edge k: ACCUM processes bit 8 at edge k+1 and bit 0 at edge k+9.
- out_valid is high from edge k+9 (latency 9 clocks, accept to result).
- Result handshake at edge m (out_valid && out_ready): out_valid low, in_ready high after m.
- No same-cycle output→input bypass. Back-to-back throughput is one word per 11 cycles with out_ready tied high.
- out_ready held low: DONE persists indefinitely; data_out/err are stable and in_ready=0.
- rst_n asserted mid-ACCUM or mid-DONE: the word is discarded and all outputs return to reset values asynchronously. No partial result is ever emitted.

## Structure
- Fibo.vh gains `CODE_W_45 (9), the FSM state encodings `DEC_IDLE/`DEC_ACCUM/`DEC_DONE, and `DEC_ACC_W (8).
- One sub-module, fns_weight_sel: combinational selection of the snapshot weight by idx, zero-extended to ACC_W, with bit 0 returning 1.
- The FSM, snapshot registers and accumulator stay in decoder_4_5.

## Test plan
Weights for all cases unless stated: FNS09=8, FNS08=5, FNS07=5, FNS06=3, FNS05=3, FNS04=2, FNS03=2, FNS02=1.
- Basic decode: codein=9'b100100001, en_flag=9'h1FF, out_ready=1 → out_valid 9 clocks after accept, data_out=12, err=0.
- Masking: same codein, en_flag=9'h1DF (wire 5 off) → data_out=9, err=0.
- Overflow: codein=9'b111000000, en_flag=9'h1FF → sum 18, data_out=2, err=1.
- Snapshot/backpressure:
  - Change codein and FNS09 to 0 during ACCUM → result unchanged.
  - Hold out_ready=0 for 5 cycles → data_out/err stable, in_ready=0; accept proceeds only after the handshake.
- Reset mid-operation: assert rst_n=0 at ACCUM cycle 4 → out_valid=0, data_out=0, err=0 immediately. After release, the next word 9'b000000011 decodes to 2.
- Throughput: 3 back-to-back words with in_valid and out_ready held high → accepts spaced 11 cycles apart, results in order.
